// File: rtl/tile_ram_writer.sv
// Queues (row,col,data) writes into the 32x32 tile RAM and issues them only while the scan is blanked.
// Optional fill-all clear engine enabled by defining TILE_CLEAR_EN.
module tile_ram_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          display_on,
    input  logic [AW-1:0] scan_addr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [4:0]    cmd_row,
    input  logic [4:0]    cmd_col,
    input  logic [DW-1:0] cmd_data,
    input  logic          clr_req,
    input  logic [DW-1:0] clr_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          busy
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t          r_fifo [DEPTH];
    logic [PW:0]   r_wptr;
    logic [PW:0]   r_rptr;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    cmd_t          w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = r_fifo[r_rptr[PW-1:0]];

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[PW-1:0]] <= '{addr: AW'({cmd_row, cmd_col}), data: cmd_data};
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

`ifdef TILE_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        r_state;
    logic          r_clr_pend;
    logic [DW-1:0] r_clr_fill;
    logic [AW-1:0] r_clr_cnt;

    assign w_pop = (r_state == S_IDLE) && !display_on && !w_empty;
    assign busy  = !w_empty || r_clr_pend || (r_state == S_CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_clr_pend <= 1'b0;
            r_clr_fill <= '0;
            r_clr_cnt  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            // A request is only captured when no clear is pending or running.
            if (clr_req && !r_clr_pend && (r_state != S_CLEAR)) begin
                r_clr_pend <= 1'b1;
                r_clr_fill <= clr_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_head.addr;
                        r_wr_data <= w_head.data;
                    end else if (r_clr_pend && w_empty) begin
                        r_state    <= S_CLEAR;
                        r_clr_pend <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (!display_on) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_clr_cnt;
                        r_wr_data <= r_clr_fill;
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                        if (r_clr_cnt == '1) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = ^{clr_req, clr_data};

    assign w_pop = !display_on && !w_empty;
    assign busy  = !w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_addr <= w_head.addr;
                r_wr_data <= w_head.data;
            end
        end
    end
`endif

    // The scan owns the address bus whenever it is active; writes only reach the RAM in blank.
    always_comb begin
        ram_addr = display_on ? scan_addr : r_wr_addr;
        ram_din  = r_wr_data;
        ram_we   = !display_on && r_wr_en;
    end
endmodule

// File: tb/tb_tile_ram_writer.sv
// Scoreboard bench for tile_ram_writer: stimulus pushes expected RAM writes, a negedge monitor checks them.
// Clear-engine scenarios run only when TILE_CLEAR_EN is defined.
module tb_tile_ram_writer;
    logic       clk = 1'b0;
    logic       reset;
    logic       display_on;
    logic [9:0] scan_addr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_row;
    logic [4:0] cmd_col;
    logic [7:0] cmd_data;
    logic       clr_req;
    logic [7:0] clr_data;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;
    logic [17:0] sb [$];

    tile_ram_writer #(.DEPTH(4), .AW(10), .DW(8)) dut (
        .clk(clk), .reset(reset), .display_on(display_on), .scan_addr(scan_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_data(cmd_data), .clr_req(clr_req), .clr_data(clr_data), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every issued RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [17:0] e;
        if (reset) begin
            if (display_on) begin
                check("we_during_scan", 32'(ram_we), 32'(0));
                check("scan_addr_mux", 32'(ram_addr), 32'(scan_addr));
            end
            if (ram_we) begin
                n_writes++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'({ram_addr, ram_din}), 32'h3ffff);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e[17:8]));
                    check("wr_data", 32'(ram_din), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        scan_addr = scan_addr + 10'd7;
    endtask

    task automatic push(input logic [4:0] r, input logic [4:0] c, input logic [7:0] d);
        int n = 0;
        cmd_row = r; cmd_col = c; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_accept", 32'(cmd_ready), 32'(1));
        if (cmd_ready) sb.push_back({r, c, d});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 32'(0));
        tick();
        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
    endtask

`ifdef TILE_CLEAR_EN
    task automatic start_clear(input logic [7:0] fill);
        clr_req = 1'b1; clr_data = fill;
        tick();
        clr_req = 1'b0; clr_data = 8'h55;
        for (int i = 0; i < 1024; i++) sb.push_back({10'(i), fill});
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (n_writes < target && n < 3000) begin
            tick();
            n++;
        end
        check("write_progress", 32'(n_writes >= target), 32'(1));
    endtask
`endif

    initial begin
        int w0;
        reset = 1'b0; display_on = 1'b0; scan_addr = '0; cmd_valid = 1'b0;
        cmd_row = '0; cmd_col = '0; cmd_data = '0; clr_req = 1'b0; clr_data = '0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ram_we", 32'(ram_we), 32'(0));
        #12 reset = 1'b1;
        tick();

        // 1: single command held off by the scan, then written once in blank.
        display_on = 1'b1;
        push(5'd3, 5'd5, 8'h07);
        tick(); tick();
        check("t1_busy_held", 32'(busy), 32'(1));
        check("t1_no_we_scan", 32'(ram_we), 32'(0));
        display_on = 1'b0;
        tick();
        check("t1_we", 32'(ram_we), 32'(1));
        check("t1_addr", 32'(ram_addr), 32'h065);
        check("t1_din", 32'(ram_din), 32'h07);
        tick();
        check("t1_we_once", 32'(ram_we), 32'(0));
        check("t1_busy_fall", 32'(busy), 32'(0));

        // 2: fill the FIFO during scan, then drain on consecutive cycles.
        display_on = 1'b1;
        push(5'd0, 5'd0, 8'h11);
        push(5'd31, 5'd31, 8'h22);
        push(5'd16, 5'd1, 8'h33);
        push(5'd1, 5'd16, 8'h44);
        check("t2_full_not_ready", 32'(cmd_ready), 32'(0));
        display_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_consec_we", 32'(ram_we), 32'(1));
            if (i == 0) check("t2_ready_after_pop", 32'(cmd_ready), 32'(1));
        end
        tick();
        check("t2_drained_we", 32'(ram_we), 32'(0));
        wait_idle(20);

        // 3: full FIFO with a continuous stream while draining; nothing lost or reordered.
        display_on = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(i), 5'(2 * i), 8'(8'h80 + i));
        display_on = 1'b0;
        w0 = n_writes;
        for (int i = 0; i < 6; i++) push(5'(20 + i), 5'(i), 8'(8'hA0 + i));
        wait_idle(30);
        check("t3_write_count", 32'(n_writes - w0), 32'(10));

`ifdef TILE_CLEAR_EN
        // 4: full clear with a scan pause and an ignored second request mid-clear.
        w0 = n_writes;
        start_clear(8'h0A);
        wait_writes(w0 + 300);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        display_on = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        display_on = 1'b0;
        wait_idle(2000);
        check("t4_clear_count", 32'(n_writes - w0), 32'(1024));

        // 5: queued commands first, then clear, then a command pushed mid-clear.
        display_on = 1'b1;
        push(5'd7, 5'd9, 8'hC1);
        push(5'd8, 5'd10, 8'hC2);
        start_clear(8'h3C);
        display_on = 1'b0;
        w0 = n_writes;
        wait_writes(w0 + 100);
        push(5'd1, 5'd2, 8'h99);
        wait_idle(2000);

        // 6a: reset mid-clear abandons everything.
        start_clear(8'h44);
        w0 = n_writes;
        wait_writes(w0 + 200);
        push(5'd2, 5'd2, 8'hEE);
        #2 reset = 1'b0;
        #1;
        check("t6_clr_we", 32'(ram_we), 32'(0));
        check("t6_clr_busy", 32'(busy), 32'(0));
        check("t6_clr_ready", 32'(cmd_ready), 32'(1));
        sb.delete();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("t6_clr_no_resume", 32'(busy), 32'(0));
`else
        // 4: clear request has no effect without the clear engine.
        w0 = n_writes;
        clr_req = 1'b1; clr_data = 8'h0A;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t4_clr_ignored_busy", 32'(busy), 32'(0));
        check("t4_clr_ignored_writes", 32'(n_writes - w0), 32'(0));
`endif

        // 6b: reset with queued commands abandons them.
        display_on = 1'b1;
        push(5'd4, 5'd4, 8'h5A);
        push(5'd5, 5'd5, 8'hA5);
        push(5'd6, 5'd6, 8'h3C);
        display_on = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t6_q_we", 32'(ram_we), 32'(0));
        check("t6_q_busy", 32'(busy), 32'(0));
        check("t6_q_ready", 32'(cmd_ready), 32'(1));
        sb.delete();
        w0 = n_writes;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("t6_q_no_writes", 32'(n_writes - w0), 32'(0));
        check("t6_q_busy_after", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
